// File: rtl/jtcop_mcu_pkg.sv
// Shared types and helpers for the cop 68000 <-> i8751 port-0 bridge.
package jtcop_mcu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACKED  = 2'd2
  } int_st_t;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/jtcop_mcu_fifo.sv
// Host command FIFO: registered count/flags, combinational head, overflow detect.
module jtcop_mcu_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   cnt,
  output logic          empty,
  output logic          full,
  output logic          push_ok,
  output logic          pop_ok,
  output logic          ovf_set
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_nxt;

  // A pop frees the slot in the same cycle, so a push to a full FIFO is legal then.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_set = push & full & ~pop_ok;
  assign head    = mem[rd_ptr];
  assign cnt_nxt = cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      empty <= cnt_nxt == '0;
      full  <= cnt_nxt == (AW+1)'(DEPTH);
    end
  end

endmodule

// File: rtl/jtcop_mcu_bridge.sv
// 68000 -> i8751 port-0 bridge: command FIFO, byte-lane read/write muxing, int1n FSM.
module jtcop_mcu_bridge
  import jtcop_mcu_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int LW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] host_din,
  input  logic          host_we,
  output logic          host_full,
  output logic [DW-1:0] host_dout,
  output logic          host_upd,
  output logic          ovf,
  input  logic [7:0]    mcu_p0o,
  output logic [7:0]    mcu_p0i,
  input  logic [LW-1:0] mcu_lane,
  input  logic          mcu_rd,
  input  logic          mcu_wr,
  input  logic          mcu_pop,
  input  logic          mcu_ack,
  output logic          mcu_intn,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_cnt
);

  localparam int NL = lanes(DW);

  logic [DW-1:0]        head;
  logic [NL-1:0][7:0]   head_b, dout_q;
  logic                 push_ok, pop_ok, ovf_set, ack_d;
  int_st_t              st, st_nxt;
  logic                 pending, pend_nxt, popped, popped_nxt;

  jtcop_mcu_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .din     (host_din),
    .push    (host_we),
    .pop     (mcu_pop),
    .head    (head),
    .cnt     (fifo_cnt),
    .empty   (fifo_empty),
    .full    (host_full),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .ovf_set (ovf_set)
  );

  assign head_b    = head;
  assign host_dout = dout_q;

  // Lane reads beyond the word width hold the previous byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcu_p0i  <= '0;
      dout_q   <= '0;
      host_upd <= 1'b0;
      ovf      <= 1'b0;
      ack_d    <= 1'b0;
    end else begin
      if (mcu_rd && int'(mcu_lane) < NL) mcu_p0i <= head_b[mcu_lane];
      for (int i = 0; i < NL; i++)
        if (mcu_wr && mcu_lane == LW'(i)) dout_q[i] <= mcu_p0o;
      host_upd <= mcu_wr && mcu_lane == LW'(NL-1);
      ack_d    <= mcu_ack;
      if (ovf_set)                ovf <= 1'b1;
      else if (mcu_ack && !ack_d) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      pending <= 1'b0;
      popped  <= 1'b0;
    end else begin
      st      <= st_nxt;
      pending <= pend_nxt;
      popped  <= popped_nxt;
    end
  end

  always_comb begin
    st_nxt     = st;
    pend_nxt   = pending;
    popped_nxt = popped;
    if (push_ok && (mcu_ack || st == ACKED)) pend_nxt = 1'b1;
    if (pop_ok && st == ACKED) popped_nxt = 1'b1;
    case (st)
      IDLE: if (!fifo_empty) begin
        st_nxt = mcu_ack ? ACKED : ASSERT;
        if (!mcu_ack) pend_nxt = 1'b0;
      end
      ASSERT: begin
        if (mcu_ack)         st_nxt = ACKED;
        else if (fifo_empty) st_nxt = IDLE;
      end
      ACKED: if (!mcu_ack) begin
        st_nxt     = (pending || (popped && !fifo_empty)) ? ASSERT : IDLE;
        pend_nxt   = 1'b0;
        popped_nxt = 1'b0;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Ack masks the line immediately so int1n is never low while acknowledged.
  assign mcu_intn = !(st == ASSERT) || mcu_ack;

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Directed bench for jtcop_mcu_bridge (DW=16, DEPTH=4).
module tb_jtcop_mcu_bridge;

  logic        clk = 0, rst = 1;
  logic [15:0] host_din = '0;
  logic        host_we = 0, host_full, host_upd, ovf;
  logic [15:0] host_dout;
  logic [7:0]  mcu_p0o = '0, mcu_p0i;
  logic [0:0]  mcu_lane = '0;
  logic        mcu_rd = 0, mcu_wr = 0, mcu_pop = 0, mcu_ack = 0;
  logic        mcu_intn, fifo_empty;
  logic [2:0]  fifo_cnt;
  int          checks = 0, errors = 0;

  jtcop_mcu_bridge #(.DW(16), .DEPTH(4), .AW(2), .LW(1)) dut (
    .clk(clk), .rst(rst), .host_din(host_din), .host_we(host_we),
    .host_full(host_full), .host_dout(host_dout), .host_upd(host_upd),
    .ovf(ovf), .mcu_p0o(mcu_p0o), .mcu_p0i(mcu_p0i), .mcu_lane(mcu_lane),
    .mcu_rd(mcu_rd), .mcu_wr(mcu_wr), .mcu_pop(mcu_pop), .mcu_ack(mcu_ack),
    .mcu_intn(mcu_intn), .fifo_empty(fifo_empty), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] w);
    host_din = w; host_we = 1; tick; host_we = 0;
  endtask

  task automatic pop1;
    mcu_pop = 1; tick; mcu_pop = 0;
  endtask

  // Reads lane1 then lane0; pops together with the lane0 read when asked.
  task automatic read_word(input logic do_pop, output logic [15:0] w);
    mcu_lane = 1; mcu_rd = 1; tick; w[15:8] = mcu_p0i;
    mcu_lane = 0; mcu_pop = do_pop; tick; w[7:0] = mcu_p0i;
    mcu_rd = 0; mcu_pop = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick; tick;
    checks++;
    if ({mcu_p0i, host_dout, host_upd, ovf, mcu_intn, fifo_cnt, fifo_empty, host_full}
        !== {8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset: p0i=%h dout=%h upd=%b ovf=%b intn=%b cnt=%0d empty=%b full=%b",
        mcu_p0i, host_dout, host_upd, ovf, mcu_intn, fifo_cnt, fifo_empty, host_full);
    end
    rst = 0; tick;
  endtask

  task automatic test_basic;
    push(16'h1234);
    checks++; if (fifo_cnt !== 3'd1 || fifo_empty !== 1'b0) begin errors++;
      $display("FAIL basic_cnt: cnt=%0d empty=%b want 1/0", fifo_cnt, fifo_empty); end
    checks++; if (mcu_intn !== 1'b1) begin errors++; $display("FAIL basic_int_early: intn=%b want 1", mcu_intn); end
    tick;
    checks++; if (mcu_intn !== 1'b0) begin errors++; $display("FAIL basic_int: intn=%b want 0", mcu_intn); end
    mcu_lane = 1; mcu_rd = 1; tick; mcu_rd = 0;
    checks++; if (mcu_p0i !== 8'h12) begin errors++; $display("FAIL basic_lane1: got %h want 12", mcu_p0i); end
    tick;
    checks++; if (mcu_p0i !== 8'h12) begin errors++; $display("FAIL basic_hold: got %h want 12", mcu_p0i); end
    mcu_lane = 0; mcu_rd = 1; tick; mcu_rd = 0;
    checks++; if (mcu_p0i !== 8'h34) begin errors++; $display("FAIL basic_lane0: got %h want 34", mcu_p0i); end
    pop1;
    checks++; if (fifo_empty !== 1'b1 || fifo_cnt !== 3'd0) begin errors++;
      $display("FAIL basic_pop: cnt=%0d empty=%b want 0/1", fifo_cnt, fifo_empty); end
    tick;
    checks++; if (mcu_intn !== 1'b1) begin errors++; $display("FAIL basic_drain_int: intn=%b want 1", mcu_intn); end
  endtask

  task automatic test_overflow;
    logic [15:0] w;
    for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
    checks++; if ({host_full, ovf, fifo_cnt} !== {1'b1, 1'b1, 3'd4}) begin errors++;
      $display("FAIL ovf_full: full=%b ovf=%b cnt=%0d want 1/1/4", host_full, ovf, fifo_cnt); end
    for (int i = 1; i <= 4; i++) begin
      read_word(1'b1, w);
      checks++; if (w !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, w, 16'hA000 + 16'(i)); end
    end
    checks++; if (fifo_empty !== 1'b1 || host_full !== 1'b0) begin errors++;
      $display("FAIL ovf_empty: empty=%b full=%b want 1/0", fifo_empty, host_full); end
    mcu_ack = 1; tick;
    checks++; if (ovf !== 1'b0 || mcu_intn !== 1'b1) begin errors++;
      $display("FAIL ovf_clear: ovf=%b intn=%b want 0/1", ovf, mcu_intn); end
    mcu_ack = 0; tick; tick;
  endtask

  task automatic test_ack_push;
    mcu_ack = 1; push(16'h5555);
    checks++; if (mcu_intn !== 1'b1) begin errors++; $display("FAIL ackpush_0: intn=%b want 1", mcu_intn); end
    tick;
    checks++; if (mcu_intn !== 1'b1) begin errors++; $display("FAIL ackpush_1: intn=%b want 1", mcu_intn); end
    tick;
    checks++; if (mcu_intn !== 1'b1) begin errors++; $display("FAIL ackpush_2: intn=%b want 1", mcu_intn); end
    mcu_ack = 0; tick;
    checks++; if (mcu_intn !== 1'b0) begin errors++; $display("FAIL ackpush_pend: intn=%b want 0", mcu_intn); end
    pop1; tick;
    checks++; if (mcu_intn !== 1'b1) begin errors++; $display("FAIL ackpush_idle: intn=%b want 1", mcu_intn); end
  endtask

  task automatic test_write;
    mcu_wr = 1; mcu_lane = 0; mcu_p0o = 8'hCD; tick;
    checks++; if (host_upd !== 1'b0 || host_dout !== 16'h00CD) begin errors++;
      $display("FAIL wr_lane0: upd=%b dout=%h want 0/00cd", host_upd, host_dout); end
    mcu_lane = 1; mcu_p0o = 8'hAB; tick; mcu_wr = 0;
    checks++; if (host_upd !== 1'b1 || host_dout !== 16'hABCD) begin errors++;
      $display("FAIL wr_lane1: upd=%b dout=%h want 1/abcd", host_upd, host_dout); end
    tick;
    checks++; if (host_upd !== 1'b0 || host_dout !== 16'hABCD) begin errors++;
      $display("FAIL wr_upd_clr: upd=%b dout=%h want 0/abcd", host_upd, host_dout); end
  endtask

  task automatic test_full_pushpop;
    logic [15:0] w;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    host_din = 16'hBEEF; host_we = 1; mcu_pop = 1; tick; host_we = 0; mcu_pop = 0;
    checks++; if ({fifo_cnt, ovf, host_full} !== {3'd4, 1'b0, 1'b1}) begin errors++;
      $display("FAIL full_pp: cnt=%0d ovf=%b full=%b want 4/0/1", fifo_cnt, ovf, host_full); end
    for (int i = 2; i <= 4; i++) begin
      read_word(1'b1, w);
      checks++; if (w !== 16'h1111 * 16'(i)) begin errors++; $display("FAIL full_pp_pop%0d: got %h want %h", i, w, 16'h1111 * 16'(i)); end
    end
    read_word(1'b0, w);
    checks++; if (w !== 16'hBEEF || fifo_cnt !== 3'd1) begin errors++;
      $display("FAIL full_pp_beef: got %h cnt=%0d want beef/1", w, fifo_cnt); end
  endtask

  task automatic test_async_reset;
    logic [15:0] w;
    push(16'h0101); push(16'h0202); tick;
    checks++; if (fifo_cnt !== 3'd3 || mcu_intn !== 1'b0) begin errors++;
      $display("FAIL arst_pre: cnt=%0d intn=%b want 3/0", fifo_cnt, mcu_intn); end
    #2 rst = 1; #1;
    checks++;
    if ({mcu_p0i, host_dout, host_upd, ovf, mcu_intn, fifo_cnt, fifo_empty, host_full}
        !== {8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL arst: p0i=%h dout=%h upd=%b ovf=%b intn=%b cnt=%0d empty=%b full=%b",
        mcu_p0i, host_dout, host_upd, ovf, mcu_intn, fifo_cnt, fifo_empty, host_full);
    end
    tick; rst = 0; tick;
    push(16'h7788);
    checks++; if (fifo_cnt !== 3'd1 || mcu_intn !== 1'b1) begin errors++;
      $display("FAIL arst_push: cnt=%0d intn=%b want 1/1", fifo_cnt, mcu_intn); end
    tick;
    checks++; if (mcu_intn !== 1'b0) begin errors++; $display("FAIL arst_int: intn=%b want 0", mcu_intn); end
    read_word(1'b0, w);
    checks++; if (w !== 16'h7788) begin errors++; $display("FAIL arst_head: got %h want 7788", w); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_ack_push;
    test_write;
    test_full_pushpop;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
